// File: rtl/spi_gap_timer.sv
// spi_gap_timer: inter-transfer gap timer for the SPI datapath.
// Counts qualified tick pulses, divided by a runtime prescaler, up to a
// runtime-loadable limit, then signals expiry once (one-shot) or on every
// terminal count (periodic). Used for chip-select restart gaps and
// inter-word delays between the bit-clock generator and the sequencer.
module spi_gap_timer #(
    parameter int          WIDTH            = 8,
    parameter int          PRESCALE_W       = 4,
    parameter int unsigned DEFAULT_LIMIT    = 8,
    parameter bit          CLEAR_ON_DISABLE = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  mode,
    input  logic                  limit_load,
    input  logic [WIDTH-1:0]      limit_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  busy,
    output logic                  done,
    output logic                  expired,
    output logic [WIDTH-1:0]      count_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Run configuration captured on start; later changes to the inputs do
    // not disturb a run in progress.
    typedef struct packed {
        logic                  mode;
        logic [PRESCALE_W-1:0] prescale;
    } run_cfg_t;

    localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE  = PRESCALE_W'(1);
    localparam logic [WIDTH-1:0]      LIM_RST  = WIDTH'(DEFAULT_LIMIT);

    state_t                state;
    run_cfg_t              cfg;
    logic [WIDTH-1:0]      counter;
    logic [WIDTH-1:0]      limit_q;
    logic [PRESCALE_W-1:0] prescaler;

    logic                  load_ok;
    logic [WIDTH-1:0]      run_limit;
    logic [WIDTH-1:0]      counter_inc;
    logic [PRESCALE_W-1:0] prescaler_inc;
    logic                  terminal;

    // Limit writes are blocked while running; a load coinciding with start
    // must take effect for that very run, hence the bypass into run_limit.
    always_comb begin
        load_ok       = limit_load && (state != RUN);
        run_limit     = load_ok ? limit_in : limit_q;
        counter_inc   = counter + CNT_ONE;
        prescaler_inc = prescaler + PRE_ONE;
        terminal      = (counter_inc == limit_q);
    end

    // State machine, counter, prescaler, limit register and expiry pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            prescaler <= '0;
            limit_q   <= LIM_RST;
            cfg       <= '0;
            expired   <= 1'b0;
        end else begin
            expired <= 1'b0;

            if (load_ok) begin
                limit_q <= limit_in;
            end

            if (abort) begin
                state     <= IDLE;
                counter   <= '0;
                prescaler <= '0;
            end else if (start) begin
                counter      <= '0;
                prescaler    <= '0;
                cfg.mode     <= mode;
                cfg.prescale <= prescale;
                // A zero limit has nothing to count: expire immediately.
                if (run_limit == '0) begin
                    state   <= DONE;
                    expired <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end else if (state == RUN) begin
                if (enable) begin
                    if (tick) begin
                        if (prescaler == cfg.prescale) begin
                            prescaler <= '0;
                            if (terminal) begin
                                expired <= 1'b1;
                                if (cfg.mode) begin
                                    counter <= '0;
                                end else begin
                                    counter <= limit_q;
                                    state   <= DONE;
                                end
                            end else begin
                                counter <= counter_inc;
                            end
                        end else begin
                            prescaler <= prescaler_inc;
                        end
                    end
                end else if (CLEAR_ON_DISABLE) begin
                    counter   <= '0;
                    prescaler <= '0;
                end
            end
        end
    end

    // Status outputs decode straight from registered state.
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        count_out = counter;
    end

endmodule

// File: doc/spi_gap_timer.md
# spi_gap_timer

Parametrised inter-transfer gap timer for the SPI datapath. It counts qualified `tick` pulses, optionally divided by a runtime prescaler, up to a runtime-loadable limit. It then signals expiry either once (one-shot) or repeatedly (periodic). It sits between the SPI bit-clock generator and the transfer sequencer, and enforces chip-select restart gaps and inter-word delays.

## Interface

- `WIDTH`, 8: counter and limit width in bits.
- `PRESCALE_W`, 4: prescaler width in bits.
- `DEFAULT_LIMIT`, 8: value of `limit` after reset. Must be nonzero and < 2^WIDTH.
- `CLEAR_ON_DISABLE`, 1: when 1, `enable` low clears the counter and prescaler. When 0, `enable` low holds them.

- `clock` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `tick` input 1: count qualifier pulse, sampled each clock.
- `enable` input 1: counting permitted.
- `start` input 1: begin or restart a timing run.
- `abort` input 1: cancel the run and return to IDLE.
- `mode` input 1: 0 = one-shot, 1 = periodic. Sampled on `start`.
- `limit_load` input 1: write `limit_in` to the limit register.
- `limit_in` input WIDTH: new terminal count.
- `prescale` input PRESCALE_W: tick divider is `prescale`+1. Sampled on `start`.
- `busy` output 1: state is RUN.
- `done` output 1: state is DONE (level, sticky).
- `expired` output 1: single-cycle pulse on each terminal count.
- `count_out` output WIDTH: current counter value.

## Operation

- States: IDLE, RUN, DONE. The `busy`, `done` and `count_out` outputs decode directly from registers.
- Reset values: state IDLE, counter 0, prescaler 0, limit `DEFAULT_LIMIT`, latched mode 0, latched prescale 0, `expired` 0.
- Priority, highest first: `reset`, `abort`, `start`, `enable`/`tick` counting.
- `abort` in any state: go to IDLE, clear counter and prescaler, no `expired`.
- `start` in any state (including RUN): go to RUN, clear counter and prescaler, latch `mode` and `prescale`. A `tick` in the same cycle is ignored.
- `start` with limit == 0: go directly to DONE and pulse `expired` once.
- `limit_load` is accepted in IDLE and DONE only and is ignored in RUN. If `limit_load` and `start` occur in the same cycle, the run uses the newly loaded `limit_in`.
- In RUN with `enable` = 1 and `tick` = 1:
  - If prescaler == latched prescale, the prescaler goes to 0 and the counter steps.
  - Otherwise the prescaler increments.
- Counter step:
  - If counter+1 == limit:
    - One-shot: go to DONE, counter holds at limit, pulse `expired`.
    - Periodic: counter goes to 0, stay in RUN, pulse `expired`.
  - Otherwise the counter increments.
- In RUN with `enable` = 0:
  - `CLEAR_ON_DISABLE` = 1: counter and prescaler clear, state stays RUN.
  - `CLEAR_ON_DISABLE` = 0: counter and prescaler hold.
- In RUN with `enable` = 1 and `tick` = 0: counter and prescaler hold.
- DONE holds until `start`, `abort` or `reset`. Ticks are ignored in IDLE and DONE.
- Arithmetic is unsigned, WIDTH bits. The counter never exceeds limit−1 in RUN, so no wrap occurs. Prescaler arithmetic is modulo 2^PRESCALE_W.

## Timing

- All outputs are registered and change only on the rising edge.
- `start` sampled at edge N: `busy` = 1 and `count_out` = 0 after edge N.
- With prescale P and limit L, `expired` asserts after the edge that samples the (L·(P+1))-th qualified tick after start. In one-shot mode `done` rises on that same edge.
- `expired` is high for exactly one cycle per terminal count. In periodic mode with P = 0, L = 1 and a continuous `tick`, `expired` stays high every cycle.
- `reset` or `abort` mid-run: outputs take their reset/IDLE values after the next edge, and any pending `expired` is suppressed.

## Test plan

- Reset, then 3 idle cycles: `busy` = 0, `done` = 0, `expired` = 0, `count_out` = 0. A subsequent start counts to the default limit 8.
- Load limit 5, prescale 0, one-shot, `start`, `tick` every cycle: `count_out` steps 1..4. `expired` and `done` rise after the 5th tick, `count_out` = 5, and further ticks have no effect.
- Load limit 3, prescale 2, periodic, continuous `tick` for 27 cycles: `expired` pulses exactly 3 times, 9 cycles apart, and `busy` stays 1.
- Limit 6, `tick` every cycle, drop `enable` for 2 cycles at count 3:
  - `CLEAR_ON_DISABLE` = 1: count returns to 0 and `expired` comes 6 ticks after re-enable.
  - `CLEAR_ON_DISABLE` = 0: count holds at 3 and `expired` comes 3 ticks after re-enable.
- Mid-run events:
  - `limit_load` of 2 during RUN with limit 4: ignored, and `expired` comes after 4 ticks.
  - `start` at count 2: count goes to 0 and the tick in that cycle is not counted.
  - `abort` and `start` in the same cycle: the run ends in IDLE.
- `start` with limit 0: `done` = 1 and a single `expired` pulse on the next edge. A `reset` asserted during RUN at count 7 (limit 8) gives no `expired`, and the limit returns to 8.
